down_counter_timer: RTL and testbench
=====================================

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter WIDTH, default 8: width of count, load data and reload register.
REQ-002 Parameter PRESCALE, default 4: clock cycles per decrement tick; used only when DOWN_TIMER_PRESCALE_EN is defined; legal range 2..256.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 clr  input  1  asynchronous, active-high reset.
REQ-005 ld  input  1  load strobe; copies d_in into count and reload register.
REQ-006 d_in  input  WIDTH  load value.
REQ-007 start  input  1  start or resume the countdown.
REQ-008 stop  input  1  pause the countdown; count is held.
REQ-009 reload_en  input  1  1 = auto-reload periodic mode; 0 = one-shot mode.
REQ-010 count_out  output  WIDTH  current count, registered.
REQ-011 busy  output  1  high while in RUN.
REQ-012 tc  output  1  terminal-count pulse, exactly one cycle wide.
REQ-013 done  output  1  high while in DONE.

Function
REQ-014 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-015 Input priority, highest first, SHALL be clr, ld, stop, start.
REQ-016 On ld in any state: count and the reload register take d_in at the next edge; IDLE/DONE go to IDLE, RUN stays RUN; the first decrement from the new value follows on a later tick.
REQ-017 On start in IDLE or DONE with count != 0: go to RUN at the same edge; start with count == 0 SHALL be ignored; start in RUN SHALL have no effect.
REQ-018 On stop in RUN: go to IDLE with count held; a later start resumes from the held value.
REQ-019 In RUN, each tick with count > 1 SHALL decrement count by 1, modulo 2^WIDTH; no underflow is possible.
REQ-020 In RUN, a tick with count == 1 and reload_en = 0 SHALL set count to 0, pulse tc, and go to DONE.
REQ-021 In RUN, a tick with count == 1 and reload_en = 1 SHALL load count from the reload register, pulse tc, and stay in RUN.
REQ-022 If the reload register is 0 at that point, the block SHALL instead set count to 0 and go to DONE.
REQ-023 Latency: with load value N and no prescaler, tc SHALL be high in the cycle after the Nth posedge following the start edge.
REQ-024 In reload mode, tc SHALL repeat every N ticks.
REQ-025 tc, busy and done SHALL be registered outputs.
REQ-026 done SHALL hold until ld, start or clr.
REQ-027 reload_en SHALL be sampled only at the terminal tick.

Reset
REQ-028 clr SHALL asynchronously force: state IDLE, count_out 0, reload register 0, tc 0, busy 0, done 0, prescaler counter 0.
REQ-029 clr asserted mid-RUN SHALL abort the countdown immediately, with no tc pulse.
REQ-030 After clr deasserts, the block SHALL respond only on the next posedge clk.

Configuration
REQ-031 Macro DOWN_TIMER_PRESCALE_EN defined: a tick SHALL occur once every PRESCALE cycles while in RUN.
REQ-032 With DOWN_TIMER_PRESCALE_EN defined, the prescaler counter SHALL clear on start, ld, stop and on entry to DONE.
REQ-033 DOWN_TIMER_PRESCALE_EN not defined: a tick SHALL occur on every cycle in RUN, and PRESCALE SHALL be ignored.

Structure
REQ-034 Shared package counters_pkg SHALL hold the state encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and the default WIDTH and PRESCALE constants.
REQ-035 One sub-module, tick_gen, SHALL contain the prescaler and generate tick; without the macro, it SHALL reduce to tick = (state == RUN).
REQ-036 The FSM, count datapath and reload register SHALL reside in down_counter_timer.

Verification
REQ-037 One-shot: ld d_in=5, start, reload_en=0 -> count_out 4,3,2,1,0 on the 5 edges after start; tc high one cycle with count 0; done=1, busy=0.
REQ-038 Periodic: ld 3, reload_en=1, start, run 10 cycles -> tc pulses on cycles 3, 6 and 9 after start; count sequence 2,1,3,2,1,3...; busy stays 1.
REQ-039 Pause/resume: ld 8, start, stop after 3 ticks -> count holds 5 in IDLE; start -> decrements resume from 5, tc after 5 further ticks.
REQ-040 Priority: ld=1, stop=1 and start=1 in the same cycle during RUN with d_in=9 -> count 9, still RUN; start and stop together in RUN -> IDLE.
REQ-041 Reset and zero: clr pulsed mid-RUN at count 3 -> outputs 0 immediately, no tc pulse; afterwards start with count 0 -> stays IDLE.
REQ-042 Prescaler (macro defined, PRESCALE=4): ld 2, start -> tc 8 cycles after start; count changes only every 4th cycle.

Source files
------------

// File: rtl/counters_pkg.sv
// Shared encodings and default sizing for the down-counter timer family.
package counters_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/tick_gen.sv
// Decrement-tick generator. With DOWN_TIMER_PRESCALE_EN defined a tick fires
// once every PRESCALE cycles in RUN; otherwise every RUN cycle is a tick.
module tick_gen
  import counters_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  state_e state_i,
  input  logic   clear_i,
  output logic   tick_o
);

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int            PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clear_i)             pre_d = '0;
    else if (state_i == RUN) pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  assign tick_o = (state_i == RUN) && (pre_q == LAST);
`else
  localparam int unused_prescale = PRESCALE;
  logic unused_ok;
  assign unused_ok = ^{clk_i, rst_i, clear_i};
  assign tick_o    = (state_i == RUN);
`endif

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-shot / auto-reload modes and a
// registered terminal-count pulse. Optional prescaler: DOWN_TIMER_PRESCALE_EN.
module down_counter_timer
  import counters_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d_in,
  input  logic             start,
  input  logic             stop,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic tick, in_run, do_stop, do_start, do_tick, at_one, at_zero, rel_ok, pre_clr;

  assign in_run   = (state_q == RUN);
  assign at_one   = (count_q == WIDTH'(1));
  assign at_zero  = (count_q == '0);
  assign rel_ok   = reload_en && (reload_q != '0);
  // stop outranks start in every state, even where it has nothing to pause
  assign do_stop  = !ld && stop;
  assign do_start = !ld && !stop && start && !in_run && !at_zero;
  assign do_tick  = !ld && !stop && in_run && tick;
  assign pre_clr  = ld || stop || do_start || (state_d == DONE && state_q != DONE);

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk_i   (clk),
    .rst_i   (clr),
    .state_i (state_q),
    .clear_i (pre_clr),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ld)                    state_d = in_run ? RUN : IDLE;
    else if (do_stop && in_run) state_d = IDLE;
    else if (do_start)         state_d = RUN;
    // a zero count in RUN (loaded while running) retires quietly to DONE
    else if (do_tick && (at_zero || (at_one && !rel_ok))) state_d = DONE;
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (ld) begin
      count_d  = d_in;
      reload_d = d_in;
    end else if (do_tick) begin
      if (at_one) begin
        tc_d    = 1'b1;
        count_d = rel_ok ? reload_q : '0;
      end else if (!at_zero) begin
        count_d = count_q - 1'b1;
      end
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign count_out = count_q;
  assign busy      = busy_q;
  assign tc        = tc_q;
  assign done      = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench: a behavioural timer model predicts each cycle's outputs,
// a separate monitor pops and compares them after every clock edge.
module tb_down_counter_timer;

  localparam int W = 8;
`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic         clk = 1'b0;
  logic         clr, ld, start, stop, reload_en;
  logic [W-1:0] d_in, count_out;
  logic         busy, tc, done;

  down_counter_timer #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk(clk), .clr(clr), .ld(ld), .d_in(d_in), .start(start), .stop(stop),
    .reload_en(reload_en), .count_out(count_out), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cnt;
    logic busy;
    logic done;
    logic tc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model state: plain integers, one tick every P cycles spent running
  int m_cnt = 0, m_rel = 0, m_mode = M_IDLE, m_run_cyc = 0;

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_step(input logic c, l, input int d, input logic s, p, r);
    exp_t e;
    e.tc = 1'b0;
    if (c) begin
      m_cnt = 0; m_rel = 0; m_mode = M_IDLE; m_run_cyc = 0;
    end else if (l) begin
      m_cnt = d; m_rel = d; m_run_cyc = 0;
      if (m_mode != M_RUN) m_mode = M_IDLE;
    end else if (p) begin
      if (m_mode == M_RUN) m_mode = M_IDLE;
      m_run_cyc = 0;
    end else if (s && m_mode != M_RUN && m_cnt != 0) begin
      m_mode = M_RUN; m_run_cyc = 0;
    end else if (m_mode == M_RUN) begin
      m_run_cyc++;
      if (m_run_cyc == P) begin
        m_run_cyc = 0;
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else if (m_cnt == 1) begin
          e.tc = 1'b1;
          if (r && m_rel != 0) m_cnt = m_rel;
          else begin m_cnt = 0; m_mode = M_DONE; end
        end else m_mode = M_DONE;
      end
    end
    e.cnt  = m_cnt;
    e.busy = (m_mode == M_RUN);
    e.done = (m_mode == M_DONE);
    return e;
  endfunction

  task automatic step(input logic c, l, input int d, input logic s, p, r);
    @(negedge clk);
    clr = c; ld = l; d_in = W'(d); start = s; stop = p; reload_en = r;
    if (c) begin
      #1;
      check_val("async_clr_count", int'(count_out), 0);
      check_val("async_clr_flags", int'({busy, tc, done}), 0);
    end
    q.push_back(model_step(c, l, d, s, p, r));
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, r);
  endtask

  // monitor: every edge presents a new output word
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (int'(count_out) != e.cnt || busy !== e.busy || done !== e.done || tc !== e.tc) begin
          n_bad++;
          $display("FAIL sb_outputs: got cnt=%0d busy=%b done=%b tc=%b expected cnt=%0d busy=%b done=%b tc=%b at %0t",
                   count_out, busy, done, tc, e.cnt, e.busy, e.done, e.tc, $time);
        end
      end
    end
  end

  initial begin
    clr = 1'b1; ld = 0; d_in = '0; start = 0; stop = 0; reload_en = 0;
    #3;
    check_val("reset_count", int'(count_out), 0);
    check_val("reset_flags", int'({busy, tc, done}), 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2, 0);

    // one-shot from 5
    step(0, 1, 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(5 * P + 3, 0);
    @(posedge clk); #2;
    check_val("oneshot_done", int'(done), 1);
    check_val("oneshot_busy", int'(busy), 0);
    check_val("oneshot_count", int'(count_out), 0);

    // periodic from 3
    step(0, 1, 3, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    idle(10 * P, 1);
    step(0, 0, 0, 0, 1, 1);

    // pause / resume from 8
    step(0, 1, 8, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(3 * P, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(3, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(5 * P + 2, 0);

    // priority: ld beats stop and start while running; stop beats start
    step(0, 1, 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2, 0);
    step(0, 1, 9, 1, 1, 0);
    @(posedge clk); #2;
    check_val("prio_ld_count", int'(count_out), 9);
    check_val("prio_ld_busy", int'(busy), 1);
    step(0, 0, 0, 1, 1, 0);
    @(posedge clk); #2;
    check_val("prio_stop_busy", int'(busy), 0);

    // clear mid-run at count 3, then start with a zero count is ignored
    step(0, 1, 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2 * P, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    @(posedge clk); #2;
    check_val("zero_start_busy", int'(busy), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic c, l, s, p, r;
      int   d;
      c = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 1) == 1;
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      step(c, l, d, s, p, r);
    end
    idle(3, 0);

    @(negedge clk);
    check_val("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
